// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for fetch plus ALU register
// instructions. It steps T0..T6 and drives the datapath strobes.
// Outputs are decoded from the registered state and the IR fed back from
// the datapath.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN. When defined, an illegal opcode
// parks the unit in TRAP until clear. When undefined, an illegal opcode
// retires as a NOP that pulses done and illegal together.
module control_sequencer #(
    parameter int NREGS = 16,
    parameter int IR_W  = 32,
    parameter int OPC_W = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             mem_ready,
    input  logic [IR_W-1:0]  ir,
    output logic [NREGS-1:0] reg_in,
    output logic [NREGS-1:0] reg_out,
    output logic [2:0]       pc_ctl,    // {PCout, PCin, IncPC}
    output logic [4:0]       mem_ctl,   // {MARin, MDMuxread, MDRin, MDRout, IRin}
    output logic [4:0]       z_ctl,     // {Yin, Zlowin, Zhighin, Zlowout, Zhighout}
    output logic [1:0]       hilo_ctl,  // {HIin, LOin}
    output logic [12:0]      alu_sel,   // one-hot, bit12=ADD ... bit0=NOT
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_DONE, ST_TRAP
    } state_t;

    // Instruction classes: 3-register ALU, MUL/DIV (HI/LO), unary, illegal
    typedef enum logic [1:0] {C_R3, C_MD, C_UN, C_ILL} cls_t;

    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    cls_t   cls;
    logic [12:0] alu_op;
    logic [OPC_W-1:0] opc;
    logic [3:0] ra, rb, rc;
    logic [NREGS-1:0] ra_oh, rb_oh, rc_oh;
    logic unused_ir;

    assign opc       = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign ra_oh     = ONE << ra;
    assign rb_oh     = ONE << rb;
    assign rc_oh     = ONE << rc;
    assign unused_ir = ^ir[14:0];

    // Opcode decode: ALU one-hot select plus instruction class
    always_comb begin
        alu_op = '0;
        cls    = C_ILL;
        case (opc)
            5'b00011: begin alu_op = 13'h1000; cls = C_R3; end // ADD
            5'b00100: begin alu_op = 13'h0800; cls = C_R3; end // SUB
            5'b00101: begin alu_op = 13'h0100; cls = C_R3; end // AND
            5'b00110: begin alu_op = 13'h0080; cls = C_R3; end // OR
            5'b00111: begin alu_op = 13'h0008; cls = C_R3; end // ROR
            5'b01000: begin alu_op = 13'h0004; cls = C_R3; end // ROL
            5'b01001: begin alu_op = 13'h0040; cls = C_R3; end // SHR
            5'b01010: begin alu_op = 13'h0020; cls = C_R3; end // SHRA
            5'b01011: begin alu_op = 13'h0010; cls = C_R3; end // SHL
            5'b01111: begin alu_op = 13'h0400; cls = C_MD; end // MUL
            5'b10000: begin alu_op = 13'h0200; cls = C_MD; end // DIV
            5'b10001: begin alu_op = 13'h0002; cls = C_UN; end // NEG
            5'b10010: begin alu_op = 13'h0001; cls = C_UN; end // NOT
            default:  begin alu_op = '0;       cls = C_ILL; end
        endcase
    end

    // State register; clear forces IDLE so every strobe drops at once
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and Moore strobes; at most one bus driver per step
    always_comb begin
        state_nxt = state;
        reg_in    = '0;
        reg_out   = '0;
        pc_ctl    = '0;
        mem_ctl   = '0;
        z_ctl     = '0;
        hilo_ctl  = '0;
        alu_sel   = '0;
        done      = 1'b0;
        illegal   = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: if (start) state_nxt = ST_T0;
            ST_T0: begin
                pc_ctl    = 3'b101;  // PCout, IncPC
                mem_ctl   = 5'b10000; // MARin
                z_ctl     = 5'b01000; // Zlowin captures PC+1
                state_nxt = ST_T1;
            end
            ST_T1: begin
                pc_ctl  = 3'b010;   // PCin
                mem_ctl = 5'b01100; // MDMuxread, MDRin held while waiting
                z_ctl   = 5'b00010; // Zlowout
                if (mem_ready) state_nxt = ST_T2;
            end
            ST_T2: begin
                mem_ctl   = 5'b00011; // MDRout, IRin
                state_nxt = ST_T3;
            end
            ST_T3: begin
                state_nxt = ST_T4;
                case (cls)
                    C_R3: begin reg_out = rb_oh; z_ctl = 5'b10000; end
                    C_MD: begin reg_out = ra_oh; z_ctl = 5'b10000; end
                    C_UN: begin reg_out = rb_oh; alu_sel = alu_op; z_ctl = 5'b01000; end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_nxt = ST_TRAP;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                endcase
            end
            ST_T4: begin
                state_nxt = ST_T5;
                case (cls)
                    C_R3: begin reg_out = rc_oh; alu_sel = alu_op; z_ctl = 5'b01000; end
                    C_MD: begin reg_out = rb_oh; alu_sel = alu_op; z_ctl = 5'b01100; end
                    default: begin reg_in = ra_oh; z_ctl = 5'b00010; state_nxt = ST_DONE; end
                endcase
            end
            ST_T5: begin
                z_ctl = 5'b00010; // Zlowout
                if (cls == C_MD) begin
                    hilo_ctl  = 2'b01; // LOin
                    state_nxt = ST_T6;
                end else begin
                    reg_in    = ra_oh;
                    state_nxt = ST_DONE;
                end
            end
            ST_T6: begin
                z_ctl     = 5'b00001; // Zhighout
                hilo_ctl  = 2'b10;    // HIin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
`ifndef CTRL_ILLEGAL_TRAP_EN
                illegal   = (cls == C_ILL);
`endif
                state_nxt = ST_IDLE;
            end
            ST_TRAP: illegal = 1'b1; // only clear leaves
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each instruction pushes its
// expected per-cycle strobe vectors, which are popped at every falling edge.
module tb_control_sequencer;
    typedef logic [62:0] vec_t; // {reg_in,reg_out,pc,mem,z,hilo,alu,busy,done,illegal}

    logic clock = 1'b0, clear, start, mem_ready;
    logic [31:0] ir;
    logic [15:0] reg_in, reg_out;
    logic [2:0]  pc_ctl;
    logic [4:0]  mem_ctl, z_ctl;
    logic [1:0]  hilo_ctl;
    logic [12:0] alu_sel;
    logic        busy, done, illegal;

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .reg_in(reg_in), .reg_out(reg_out), .pc_ctl(pc_ctl), .mem_ctl(mem_ctl),
        .z_ctl(z_ctl), .hilo_ctl(hilo_ctl), .alu_sel(alu_sel),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clock = ~clock;

    vec_t obs;
    assign obs = {reg_in, reg_out, pc_ctl, mem_ctl, z_ctl, hilo_ctl, alu_sel, busy, done, illegal};

    vec_t sb[$];
    int   n_cmp = 0, n_err = 0;

    function automatic vec_t mk(logic [15:0] ri, logic [15:0] ro, logic [2:0] pc,
                                logic [4:0] mem, logic [4:0] z, logic [1:0] hl,
                                logic [12:0] alu, logic b, logic d, logic il);
        return {ri, ro, pc, mem, z, hl, alu, b, d, il};
    endfunction

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    vec_t F0, F1, F2, DN, DNI, TRP, T3NOP;

    // Fetch prefix is queued ahead of body; T1 lasts stall+1 cycles.
    // start is raised during DONE (must be ignored) and dropped at IDLE.
    task automatic run(input string tag, input logic [31:0] i, input int stall, input vec_t body[$]);
        int idx;
        sb.push_back(F0);
        repeat (stall + 1) sb.push_back(F1);
        sb.push_back(F2);
        foreach (body[k]) sb.push_back(body[k]);
        @(negedge clock);
        ir = i; start = 1'b1; mem_ready = (stall == 0);
        idx = 0;
        while (sb.size() != 0) begin
            @(negedge clock);
            chk($sformatf("%s[%0d]", tag, idx), obs, sb.pop_front());
            start     = (sb.size() == 1);
            mem_ready = (idx > stall);
            idx++;
        end
        start = 1'b0; mem_ready = 1'b1;
    endtask

    function automatic logic [31:0] enc(logic [4:0] op, logic [3:0] a, logic [3:0] b, logic [3:0] c);
        return {op, a, b, c, 15'h0};
    endfunction

    initial begin
        vec_t q[$];
        F0    = mk(0, 0, 3'b101, 5'b10000, 5'b01000, 0, 0, 1, 0, 0);
        F1    = mk(0, 0, 3'b010, 5'b01100, 5'b00010, 0, 0, 1, 0, 0);
        F2    = mk(0, 0, 3'b000, 5'b00011, 5'b00000, 0, 0, 1, 0, 0);
        DN    = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        DNI   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        TRP   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        T3NOP = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        clear = 1'b1; start = 1'b0; mem_ready = 1'b1; ir = '0;
        repeat (2) @(negedge clock);
        chk("reset", obs, '0);
        clear = 1'b0;
        @(negedge clock);
        chk("idle", obs, '0);

        // MUL R4,R5
        q = '{mk(0, 16'h0010, 0, 0, 5'b10000, 0, 0, 1, 0, 0),
              mk(0, 16'h0020, 0, 0, 5'b01100, 0, 13'h0400, 1, 0, 0),
              mk(0, 0, 0, 0, 5'b00010, 2'b01, 0, 1, 0, 0),
              mk(0, 0, 0, 0, 5'b00001, 2'b10, 0, 1, 0, 0), DN, '0};
        run("mul", 32'h7A280000, 0, q);

        // ADD R1,R2,R3
        q = '{mk(0, 16'h0004, 0, 0, 5'b10000, 0, 0, 1, 0, 0),
              mk(0, 16'h0008, 0, 0, 5'b01000, 0, 13'h1000, 1, 0, 0),
              mk(16'h0002, 0, 0, 0, 5'b00010, 0, 0, 1, 0, 0), DN, '0};
        run("add", 32'h18918000, 0, q);

        // NEG R6,R7
        q = '{mk(0, 16'h0080, 0, 0, 5'b01000, 0, 13'h0002, 1, 0, 0),
              mk(16'h0040, 0, 0, 0, 5'b00010, 0, 0, 1, 0, 0), DN, '0};
        run("neg", 32'h8B380000, 0, q);

        // SUB R15,R0,R14 with 3-cycle memory stall (T1 lasts 4 cycles)
        q = '{mk(0, 16'h0001, 0, 0, 5'b10000, 0, 0, 1, 0, 0),
              mk(0, 16'h4000, 0, 0, 5'b01000, 0, 13'h0800, 1, 0, 0),
              mk(16'h8000, 0, 0, 0, 5'b00010, 0, 0, 1, 0, 0), DN, '0};
        run("sub_stall", enc(5'b00100, 4'hF, 4'h0, 4'hE), 3, q);

        // DIV R3,R9
        q = '{mk(0, 16'h0008, 0, 0, 5'b10000, 0, 0, 1, 0, 0),
              mk(0, 16'h0200, 0, 0, 5'b01100, 0, 13'h0200, 1, 0, 0),
              mk(0, 0, 0, 0, 5'b00010, 2'b01, 0, 1, 0, 0),
              mk(0, 0, 0, 0, 5'b00001, 2'b10, 0, 1, 0, 0), DN, '0};
        run("div", enc(5'b10000, 4'h3, 4'h9, 4'h0), 1, q);

        // NOT R12,R0 and ROL R0,R10,R5
        q = '{mk(0, 16'h0001, 0, 0, 5'b01000, 0, 13'h0001, 1, 0, 0),
              mk(16'h1000, 0, 0, 0, 5'b00010, 0, 0, 1, 0, 0), DN, '0};
        run("not", enc(5'b10010, 4'hC, 4'h0, 4'h0), 0, q);
        q = '{mk(0, 16'h0400, 0, 0, 5'b10000, 0, 0, 1, 0, 0),
              mk(0, 16'h0020, 0, 0, 5'b01000, 0, 13'h0004, 1, 0, 0),
              mk(16'h0001, 0, 0, 0, 5'b00010, 0, 0, 1, 0, 0), DN, '0};
        run("rol", enc(5'b01000, 4'h0, 4'hA, 4'h5), 0, q);

        // Async clear mid-T4 with start held high, then restart from T0
        @(negedge clock);
        ir = 32'h18918000; start = 1'b1; mem_ready = 1'b1;
        q = '{F0, F1, F2, mk(0, 16'h0004, 0, 0, 5'b10000, 0, 0, 1, 0, 0),
              mk(0, 16'h0008, 0, 0, 5'b01000, 0, 13'h1000, 1, 0, 0)};
        foreach (q[k]) begin
            @(negedge clock);
            chk($sformatf("clr_pre[%0d]", k), obs, q[k]);
        end
        #2 clear = 1'b1;
        #1 chk("clr_async", obs, '0);
        @(negedge clock);
        chk("clr_hold", obs, '0);
        clear = 1'b0;
        @(negedge clock);
        chk("clr_restart", obs, F0);
        start = 1'b0;
        q = '{F1, F2, mk(0, 16'h0004, 0, 0, 5'b10000, 0, 0, 1, 0, 0),
              mk(0, 16'h0008, 0, 0, 5'b01000, 0, 13'h1000, 1, 0, 0),
              mk(16'h0002, 0, 0, 0, 5'b00010, 0, 0, 1, 0, 0), DN, '0};
        foreach (q[k]) sb.push_back(q[k]);
        for (int k = 0; sb.size() != 0; k++) begin
            @(negedge clock);
            chk($sformatf("clr_post[%0d]", k), obs, sb.pop_front());
        end

        // Illegal opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
        q = '{T3NOP, TRP, TRP, TRP, TRP};
        run("trap", 32'hF8000000, 0, q);
        @(negedge clock);
        chk("trap_stay", obs, TRP);
        #2 clear = 1'b1;
        #1 chk("trap_clr", obs, '0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        chk("trap_idle", obs, '0);
`else
        q = '{T3NOP, DNI, '0};
        run("illegal", 32'hF8000000, 0, q);
        @(negedge clock);
        chk("ill_idle", obs, '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
